// File: rtl/hist_pkg.sv
// Shared definitions for the histogram bin accumulator: FSM encoding,
// saturation mode constants and the address-width helper.
package hist_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Never below one bit, so a degenerate single-bin histogram still has an index.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/hist_dpram.sv
// Generic inferred dual-port RAM: single clock, global clock enable,
// registered reads, old data returned when a read meets a write.
module hist_dpram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  // Port A: read and write use independent addresses (read-ahead / write-back).
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_raddr,
  output logic [DATA_W-1:0] a_q,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  // Port B: readout, or the clear sweep.
  input  logic              b_re,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array itself has no reset; resetting it would prevent RAM
  // inference. Only the output registers are reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (a_we) mem[a_waddr] <= a_wdata;
      if (b_we) mem[b_addr]  <= b_wdata;
    end
  end

  // Non-blocking writes above mean these reads see the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ce) begin
      if (a_re) a_q <= mem[a_raddr];
      if (b_re) b_q <= mem[b_addr];
    end
  end

endmodule

// File: rtl/hist_bin_accumulator.sv
// Weighted histogram accumulator: two-stage read-modify-write into a dual-port
// RAM, with back-to-back forwarding, saturation/wrap, clear sweep and readout.
module hist_bin_accumulator
  import hist_pkg::*;
#(
  parameter int  BIN_WIDTH    = 16,
  parameter int  HIST_DEPTH   = 1024,
  parameter int  WEIGHT_WIDTH = 8,
  parameter int  SATURATE     = 1,
  localparam int ADDR_W       = addr_width(HIST_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       in_bin,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  output logic                    in_ready,
  input  logic                    clear_req,
  output logic                    clear_busy,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  output logic [BIN_WIDTH-1:0]    rd_data,
  output logic                    sat_flag
);

  localparam int SUM_W = BIN_WIDTH + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HIST_DEPTH - 1);

  state_t                  state;
  logic [ADDR_W-1:0]       sweep_cnt;
  logic                    ready_q;

  logic                    s1_valid;
  logic [ADDR_W-1:0]       s1_bin;
  logic [WEIGHT_WIDTH-1:0] s1_weight;
  logic                    last_valid;
  logic [ADDR_W-1:0]       last_bin;
  logic [BIN_WIDTH-1:0]    last_sum;

  logic                    accept;
  logic                    in_clear;
  logic                    fwd_hit;
  logic [BIN_WIDTH-1:0]    q_a;
  logic [BIN_WIDTH-1:0]    operand;
  logic [SUM_W-1:0]        sum;
  logic                    carry;
  logic [BIN_WIDTH-1:0]    wr_data;

  // A sample offered together with clear_req is refused, so nothing new can
  // enter the pipeline once the sweep has been requested.
  assign in_ready = enable & ready_q & ~clear_req;
  assign accept   = in_valid & in_ready;
  assign in_clear = (state == ST_CLEAR);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    fwd_hit = last_valid & (last_bin == s1_bin);
    operand = fwd_hit ? last_sum : q_a;
    sum     = {1'b0, operand} + SUM_W'(s1_weight);
    carry   = sum[BIN_WIDTH];
    wr_data = sum[BIN_WIDTH-1:0];
    if (carry && (SATURATE == SAT_CLAMP)) wr_data = '1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_bin     <= '0;
      s1_weight  <= '0;
      last_valid <= 1'b0;
      last_bin   <= '0;
      last_sum   <= '0;
    end else if (enable) begin
      s1_valid   <= accept;
      if (accept) begin
        s1_bin    <= in_bin;
        s1_weight <= in_weight;
      end
      // The previous cycle's write is the only one the RAM read can miss.
      last_valid <= s1_valid;
      if (s1_valid) begin
        last_bin <= s1_bin;
        last_sum <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ACCUM;
      sweep_cnt  <= '0;
      ready_q    <= 1'b0;
      clear_busy <= 1'b0;
      rd_valid   <= 1'b0;
      sat_flag   <= 1'b0;
    end else if (enable) begin
      rd_valid <= rd_req & ~in_clear;
      case (state)
        ST_ACCUM: begin
          if (clear_req) begin
            state      <= ST_CLEAR;
            sweep_cnt  <= '0;
            ready_q    <= 1'b0;
            clear_busy <= 1'b1;
            sat_flag   <= 1'b0;
          end else begin
            ready_q <= 1'b1;
            if (s1_valid && carry) sat_flag <= 1'b1;
          end
        end
        ST_CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state      <= ST_DRAIN;
            clear_busy <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state   <= ST_ACCUM;
          ready_q <= 1'b1;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  hist_dpram #(
    .DATA_W (BIN_WIDTH),
    .DEPTH  (HIST_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .ce      (enable),
    .a_re    (accept),
    .a_raddr (in_bin),
    .a_q     (q_a),
    .a_we    (s1_valid),
    .a_waddr (s1_bin),
    .a_wdata (wr_data),
    .b_re    (rd_req & ~in_clear),
    .b_we    (in_clear),
    .b_addr  (in_clear ? sweep_cnt : rd_addr),
    .b_wdata ('0),
    .b_q     (rd_data)
  );

endmodule

// File: doc/hist_bin_accumulator.md
Name: hist_bin_accumulator

Overview:
- Parametrised successor of the histogram RAM read-modify-write cell.
- Accepts one weighted sample per cycle and adds it to a bin in a dual-port RAM.
- Handles back-to-back hits on the same bin by forwarding.
- Adds optional saturation, a self-timed clear sweep and a concurrent readout port.
- Sits between the pixel/feature binning stage and the histogram readout/bus interface.

Parameters:
BIN_WIDTH, 16, width of each bin counter
HIST_DEPTH, 1024, number of bins; localparam ADDR_W = $clog2(HIST_DEPTH)
WEIGHT_WIDTH, 8, width of sample increment; must be <= BIN_WIDTH
SATURATE, 1, 1 = clamp at all-ones, 0 = modulo 2^BIN_WIDTH wrap

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global clock enable; low freezes all state, RAM and outputs
in_valid  in  1  sample strobe
in_bin  in  ADDR_W  bin index of sample
in_weight  in  WEIGHT_WIDTH  increment, zero-extended
in_ready  out  1  high when a sample can be accepted
clear_req  in  1  pulse: start zeroing all bins
clear_busy  out  1  high during clear sweep
rd_req  in  1  readout strobe
rd_addr  in  ADDR_W  readout bin
rd_valid  out  1  rd_data valid
rd_data  out  BIN_WIDTH  readout value
sat_flag  out  1  sticky: some bin saturated or wrapped since last clear

Behaviour:
- Reset values: in_ready=0 for one cycle then 1, clear_busy=0, rd_valid=0, rd_data=0, sat_flag=0, FSM=ACCUM. RAM contents after reset are undefined; the user issues clear_req.
- FSM states:
  - ACCUM: the normal state.
  - CLEAR: in_ready=0, clear_busy=1, sweep counter writes 0 to addr 0..HIST_DEPTH-1, one bin per enabled cycle; after HIST_DEPTH writes go to DRAIN.
  - DRAIN: one cycle, clear_busy=0, then ACCUM.
- clear_req in ACCUM: go to CLEAR on the next edge. Ignored in CLEAR/DRAIN. sat_flag clears on entering CLEAR.
- Pipeline, with all counts in enabled cycles:
  - S0, accept: in_valid & in_ready registers bin/weight and issues the port-A read.
  - S1: RAM q is valid; operand = fwd_hit ? last_sum : q; sum = operand + weight; port-A write of sum at the same address in the same cycle.
  - Throughput 1 sample/cycle; update latency 2 cycles from accept to RAM.
- Forwarding: fwd_hit when the S1 address equals the address written in the previous cycle. This covers consecutive identical bins. A same-bin sample 2+ cycles later reads fresh RAM data because the RAM is read-during-write OLD_DATA. Forwarding is mandatory: N consecutive hits on bin k add N*weight.
- Arithmetic: sum is computed at BIN_WIDTH+1 bits.
  - On carry with SATURATE=1: write all-ones and set sat_flag.
  - On carry with SATURATE=0: write the low BIN_WIDTH bits and set sat_flag.
  - A bin already at all-ones with weight 0 is not a saturation event.
- Samples accepted before clear_req drain through S1 before the sweep reaches their bin, so they are overwritten. The sweep starts at addr 0, and the pipeline drains within 2 cycles.
- Readout uses port B, is allowed in any state, and has latency 1: rd_valid pulses the cycle after rd_req.
  - During CLEAR, port B is owned by the sweep: rd_req is ignored and rd_valid stays 0.
  - Reads may see a value up to one in-flight update stale.
  - Port B never writes in ACCUM.
- enable low: no state, counter, RAM clock-enable or output change; in_ready reads 0.
- Reset mid-CLEAR: abort to ACCUM; bins not yet swept are undefined.

Decomposition:
- Package hist_pkg: ADDR_W helper function, FSM state encoding (ACCUM/CLEAR/DRAIN), SATURATE mode constants.
- One sub-module, hist_dpram: generic inferred true dual-port RAM.
  - Registered read, single clock, clock enable.
  - Mixed-port OLD_DATA read.
  - No vendor primitive, so the block is portable off Cyclone IV.

Test Plan:
- Reset, clear_req, wait 1024+1 cycles; read bins 0, 511, 1023 -> each 0, clear_busy low, sat_flag 0.
- Samples bin 5 weight 3 on 4 consecutive cycles -> bin 5 reads 12 (forwarding). Then bin 5, bin 6, bin 5 alternating, weight 1 -> bin 5 = 14, bin 6 = 1.
- SATURATE=1, BIN_WIDTH=8: 300 hits of weight 1 on bin 7 -> bin 7 = 255, sat_flag 1. SATURATE=0 same stimulus -> bin 7 = 44, sat_flag 1.
- clear_req issued 1 cycle after accepting bin 0 weight 9 -> after sweep bin 0 = 0; in_ready low during the sweep; a second clear_req mid-sweep is ignored (sweep length unchanged).
- enable held low 5 cycles mid-stream with in_valid high -> no acceptance and no RAM change; results are identical to the same stimulus with no stall.
- reset_n asserted at sweep cycle 100 -> clear_busy=0 and in_ready=1 one cycle after release; a following full clear -> all bins 0.
